// File: rtl/lfsr_seq_ctrl.sv
// ============================================================================
// lfsr_seq_ctrl : CSR-mapped sequencer that seeds a fixed-latency LFSR pipeline
//                 and chains each result back as the next seed.
// Optional completion interrupt: define LFSR_SEQ_CTRL_IRQ_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr_seq_ctrl #(
  parameter int LATENCY = 32,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  output logic [31:0] lfsr_seed,
  output logic        seed_vld,
  input  logic [31:0] lfsr_out,
  output logic        irq
);

  localparam logic [4:0] c_addr_ctrl   = 5'h00;
  localparam logic [4:0] c_addr_status = 5'h04;
  localparam logic [4:0] c_addr_seed   = 5'h08;
  localparam logic [4:0] c_addr_result = 5'h0C;
  localparam logic [4:0] c_addr_count  = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        seed_q, seed_d;
  logic [31:0]        result_q, result_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [31:0]        cur_seed_q, cur_seed_d;
  logic [7:0]         wait_q, wait_d;
  logic               done_q, done_d;

  logic w_idle, w_wr, w_rd, w_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      seed_q      <= '0;
      result_q    <= '0;
      count_q     <= CNT_W'(1);
      remaining_q <= '0;
      cur_seed_q  <= '0;
      wait_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      seed_q      <= seed_d;
      result_q    <= result_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      cur_seed_q  <= cur_seed_d;
      wait_q      <= wait_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = bus_req;
    rdata_d     = '0;
    seed_d      = seed_q;
    result_d    = result_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    cur_seed_d  = cur_seed_q;
    wait_d      = wait_q;
    done_d      = done_q;

    w_idle  = (state_q == ST_IDLE);
    w_wr    = bus_req & bus_we;
    w_rd    = bus_req & ~bus_we;
    w_start = w_wr & w_idle & (bus_addr == c_addr_ctrl) & bus_wdata[0];

    if (w_rd) begin
      case (bus_addr)
        c_addr_status: rdata_d = {30'd0, done_q, ~w_idle};
        c_addr_seed:   rdata_d = seed_q;
        c_addr_result: rdata_d = result_q;
        c_addr_count:  rdata_d = 32'(count_q);
        default:       rdata_d = '0;
      endcase
    end

    // Configuration is frozen for the whole run; only done-clear is honoured while busy.
    if (w_wr) begin
      if (w_idle && bus_addr == c_addr_seed)  seed_d  = bus_wdata;
      if (w_idle && bus_addr == c_addr_count) count_d = bus_wdata[CNT_W-1:0];
      if (bus_addr == c_addr_status && bus_wdata[1]) done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          remaining_d = (count_q == '0) ? CNT_W'(1) : count_q;
          cur_seed_d  = seed_q;
          done_d      = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wait_d  = 8'(LATENCY);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q - 8'd1;
        if (wait_q == 8'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        result_d    = lfsr_out;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q > CNT_W'(1)) begin
          cur_seed_d = lfsr_out;
          state_d    = ST_LOAD;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  // cur_seed only changes on the way into LOAD, so it doubles as the held seed output.
  assign lfsr_seed = cur_seed_q;
  assign seed_vld  = (state_q == ST_LOAD);

`ifdef LFSR_SEQ_CTRL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (state_q == ST_CAPTURE) && (remaining_q <= CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a stub pipeline: lfsr_out = seed + 1, LATENCY cycles later.
`default_nettype none

module tb_lfsr_seq_ctrl;
  localparam int LATENCY = 32;
  localparam int CNT_W   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] lfsr_seed;
  logic        seed_vld;
  logic [31:0] lfsr_out;
  logic        irq;

  lfsr_seq_ctrl #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .lfsr_seed(lfsr_seed), .seed_vld(seed_vld), .lfsr_out(lfsr_out), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [31:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= lfsr_seed + 32'd1;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign lfsr_out = pipe[LATENCY-1];

  int          cyc = 0;
  int          vld_n = 0;
  int          irq_n = 0;
  int          irq_cyc = 0;
  int          vld_cyc [8];
  logic [31:0] vld_seed [8];

  always @(negedge clk) begin
    cyc++;
    if (seed_vld) begin
      vld_cyc[vld_n & 7]  = cyc;
      vld_seed[vld_n & 7] = lfsr_seed;
      vld_n++;
    end
    if (irq) begin
      irq_n++;
      irq_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    @(posedge clk); #1;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_req = 1'b0; bus_we = 1'b0;
    chk("ack", {31'd0, bus_ack}, 32'd1);
    rd = bus_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, a, 32'd0, v);
    chk(tag, v, exp);
  endtask

  int base;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ack", {31'd0, bus_ack}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_vld", {31'd0, seed_vld}, 32'd0);
    chk("rst_seed", lfsr_seed, 32'd0);
    rd_chk("rst_result", 5'h0C, 32'h0000_0000);
    rd_chk("rst_count", 5'h10, 32'h0000_0001);
    rd_chk("rst_status", 5'h04, 32'h0000_0000);
    rd_chk("rst_seedreg", 5'h08, 32'h0000_0000);
    rd_chk("unmapped", 5'h14, 32'h0000_0000);
    @(negedge clk);
    chk("rdata_idle", bus_rdata, 32'd0);

    // Single step
    wr(5'h08, 32'h1234_FADC);
    wr(5'h10, 32'd1);
    base = vld_n;
    wr(5'h00, 32'd1);
    repeat (32) @(posedge clk);
    rd_chk("single_busy", 5'h04, 32'h1);
    rd_chk("single_done", 5'h04, 32'h2);
    rd_chk("single_result", 5'h0C, 32'h1234_FADD);
    chk("single_vld_n", 32'(vld_n - base), 32'd1);
    chk("single_vld_seed", vld_seed[base & 7], 32'h1234_FADC);

    // Chained run of three steps
    wr(5'h08, 32'hDEAD_BEEF);
    wr(5'h10, 32'd3);
    base = vld_n;
    wr(5'h00, 32'd1);
    repeat (101) @(posedge clk);
    rd_chk("chain_done_102", 5'h04, 32'h2);
    rd_chk("chain_result", 5'h0C, 32'hDEAD_BEF2);
    chk("chain_vld_n", 32'(vld_n - base), 32'd3);
    chk("chain_space1", 32'(vld_cyc[(base+1) & 7] - vld_cyc[base & 7]), 32'd34);
    chk("chain_space2", 32'(vld_cyc[(base+2) & 7] - vld_cyc[(base+1) & 7]), 32'd34);
    chk("chain_seed0", vld_seed[base & 7], 32'hDEAD_BEEF);
    chk("chain_seed1", vld_seed[(base+1) & 7], 32'hDEAD_BEF0);
    chk("chain_seed2", vld_seed[(base+2) & 7], 32'hDEAD_BEF1);

    // Writes while busy are ignored
    wr(5'h08, 32'h0000_0041);
    wr(5'h10, 32'd1);
    base = vld_n;
    wr(5'h00, 32'd1);
    wr(5'h08, 32'hFFFF_FFFF);
    wr(5'h10, 32'd7);
    wr(5'h00, 32'd1);
    rd_chk("busy_seed_kept", 5'h08, 32'h0000_0041);
    rd_chk("busy_count_kept", 5'h10, 32'h0000_0001);
    rd_chk("busy_status", 5'h04, 32'h1);
    repeat (100) @(posedge clk);
    chk("busy_one_run", 32'(vld_n - base), 32'd1);
    rd_chk("busy_result", 5'h0C, 32'h0000_0042);

    // COUNT = 0 behaves as one step
    wr(5'h08, 32'h0000_0100);
    wr(5'h10, 32'd0);
    base = vld_n;
    wr(5'h00, 32'd1);
    repeat (80) @(posedge clk);
    chk("cnt0_one_step", 32'(vld_n - base), 32'd1);
    rd_chk("cnt0_result", 5'h0C, 32'h0000_0101);
    rd_chk("cnt0_status", 5'h04, 32'h2);

    // Done clear
    wr(5'h04, 32'h2);
    rd_chk("done_clear", 5'h04, 32'h0);

`ifdef LFSR_SEQ_CTRL_IRQ_EN
    wr(5'h08, 32'h0000_0010);
    wr(5'h10, 32'd2);
    base = vld_n;
    irq_n = 0;
    wr(5'h00, 32'd1);
    repeat (80) @(posedge clk);
    chk("irq_count", 32'(irq_n), 32'd1);
    chk("irq_timing", 32'(irq_cyc - vld_cyc[(base+1) & 7]), 32'(LATENCY + 2));
    rd_chk("irq_result", 5'h0C, 32'h0000_0012);
`else
    chk("irq_never", 32'(irq_n), 32'd0);
`endif

    // Mid-run reset, 10 cycles into WAIT
    wr(5'h08, 32'h0000_0005);
    wr(5'h10, 32'd2);
    base = vld_n;
    wr(5'h00, 32'd1);
    repeat (10) @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst_vld", {31'd0, seed_vld}, 32'd0);
    chk("mrst_seed", lfsr_seed, 32'd0);
    chk("mrst_irq", {31'd0, irq}, 32'd0);
    rd_chk("mrst_status", 5'h04, 32'h0);
    rd_chk("mrst_result", 5'h0C, 32'h0);
    repeat (100) @(posedge clk);
    chk("mrst_no_more_vld", 32'(vld_n - base), 32'd1);
    rd_chk("mrst_result_late", 5'h0C, 32'h0);
    rd_chk("mrst_status_late", 5'h04, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
